// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter types, limits and priority-isolation helper
package arb_pkg;

    localparam int ARB_REQ_NUM_DEFAULT = 4;
    localparam int ARB_REQ_NUM_MAX     = 64;

    // Widest request/grant vector any arbiter in the family can carry.
    typedef logic [ARB_REQ_NUM_MAX-1:0] arb_vec_t;

    // Returns the single highest-priority set bit of the low n bits of v.
    // With lsb_high set, the lowest index wins; otherwise the highest index wins.
    function automatic arb_vec_t ffs_onehot(input arb_vec_t v, input int n, input bit lsb_high);
        arb_vec_t r;
        bit       found;
        r     = '0;
        found = 1'b0;
        if (lsb_high) begin
            for (int i = 0; i < ARB_REQ_NUM_MAX; i++) begin
                if (!found && (i < n) && v[i]) begin
                    r[i]  = 1'b1;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = ARB_REQ_NUM_MAX - 1; i >= 0; i--) begin
                if (!found && (i < n) && v[i]) begin
                    r[i]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// rtl/arb_prio_sel.sv - combinational isolation of the highest-priority request bit
module arb_prio_sel
    import arb_pkg::*;
#(
    parameter int REQ_NUM  = ARB_REQ_NUM_DEFAULT,
    parameter bit LSB_HIGH = 1'b1
) (
    input  logic [REQ_NUM-1:0] i_req,
    output logic [REQ_NUM-1:0] o_sel
);

    localparam logic [REQ_NUM-1:0] ONE = REQ_NUM'(1);

    generate
        if (LSB_HIGH) begin : g_lsb
            // Two's-complement trick keeps only the lowest set bit.
            assign o_sel = i_req & (~i_req + ONE);
        end else begin : g_msb
            logic [REQ_NUM-1:0] w_rev;
            logic [REQ_NUM-1:0] w_rev_sel;

            // Mirror the vector so the highest index becomes the lowest.
            always_comb begin
                w_rev = '0;
                for (int i = 0; i < REQ_NUM; i++) begin
                    w_rev[i] = i_req[REQ_NUM-1-i];
                end
            end

            assign w_rev_sel = w_rev & (~w_rev + ONE);

            // Mirror the isolated bit back into original bit order.
            always_comb begin
                o_sel = '0;
                for (int i = 0; i < REQ_NUM; i++) begin
                    o_sel[i] = w_rev_sel[REQ_NUM-1-i];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/arb_fixed_priority_abs.sv
// rtl/arb_fixed_priority_abs.sv - preemptive fixed-priority arbiter with registered one-hot grant
module arb_fixed_priority_abs
    import arb_pkg::*;
#(
    parameter int REQ_NUM  = ARB_REQ_NUM_DEFAULT,
    parameter bit LSB_HIGH = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] req,
    output logic [REQ_NUM-1:0] grant
);

    logic [REQ_NUM-1:0] w_next_grant;
    logic [REQ_NUM-1:0] r_grant;

    arb_prio_sel #(
        .REQ_NUM  (REQ_NUM),
        .LSB_HIGH (LSB_HIGH)
    ) u_prio_sel (
        .i_req (req),
        .o_sel (w_next_grant)
    );

    // Grant follows the current winner every edge; no memory survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
        end else begin
            r_grant <= w_next_grant;
        end
    end

    assign grant = r_grant;

endmodule

// File: tb/tb_arb_fixed_priority_abs.sv
// tb/tb_arb_fixed_priority_abs.sv - scoreboard bench for LSB- and MSB-priority arbiter builds
module tb_arb_fixed_priority_abs;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant_l;
    logic [3:0] grant_m;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] q_exp_l[$];
    logic [3:0] q_exp_m[$];

    arb_fixed_priority_abs #(.REQ_NUM(4), .LSB_HIGH(1'b1)) u_dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant_l)
    );

    arb_fixed_priority_abs #(.REQ_NUM(4), .LSB_HIGH(1'b0)) u_dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_lsb(input logic [3:0] r);
        return r & (~r + 4'd1);
    endfunction

    function automatic logic [3:0] model_msb(input logic [3:0] r);
        if (r[3]) return 4'b1000;
        if (r[2]) return 4'b0100;
        if (r[1]) return 4'b0010;
        if (r[0]) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_onehot(input string tag, input logic [3:0] obs);
        n_assert++;
        assert ($onehot0(obs)) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=onehot0", tag, obs);
        end
    endtask

    // Drive req away from the edge, push expectations, then check after the edge.
    task automatic step(input string tag, input logic [3:0] v);
        logic [3:0] e_l;
        logic [3:0] e_m;
        @(negedge clk);
        req = v;
        q_exp_l.push_back(model_lsb(v));
        q_exp_m.push_back(model_msb(v));
        @(posedge clk);
        #1;
        e_l = (q_exp_l.size() > 0) ? q_exp_l.pop_front() : 4'bxxxx;
        e_m = (q_exp_m.size() > 0) ? q_exp_m.pop_front() : 4'bxxxx;
        chk({tag, "_lsb"}, grant_l, e_l);
        chk({tag, "_msb"}, grant_m, e_m);
        chk({tag, "_lsb_past"}, grant_l & ~v, 4'b0000);
        chk({tag, "_msb_past"}, grant_m & ~v, 4'b0000);
        chk_onehot({tag, "_lsb_oh"}, grant_l);
        chk_onehot({tag, "_msb_oh"}, grant_m);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        #1;
        chk("reset_now_lsb", grant_l, 4'b0000);
        chk("reset_now_msb", grant_m, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_lsb", grant_l, 4'b0000);
        chk("reset_hold_msb", grant_m, 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;
        step("first_grant", 4'b1111);

        step("single_0100", 4'b0100);
        step("none_0000",   4'b0000);
        step("sim_1110",    4'b1110);
        step("sim_1111",    4'b1111);
        step("sim_1000",    4'b1000);
        step("pre_1000",    4'b1000);
        step("pre_1001",    4'b1001);
        step("rel_1000",    4'b1000);
        step("msb_0110",    4'b0110);
        step("msb_1001",    4'b1001);

        // Asynchronous clear in the middle of a cycle while a grant is held.
        step("pre_rst",     4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clear_lsb", grant_l, 4'b0000);
        chk("async_clear_msb", grant_m, 4'b0000);
        @(negedge clk);
        req = 4'b1111;
        @(posedge clk);
        #1;
        chk("in_reset_lsb", grant_l, 4'b0000);
        chk("in_reset_msb", grant_m, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        step("resume_1111", 4'b1111);
        step("resume_0110", 4'b0110);

        for (int i = 0; i < 1000; i++) begin
            step("rand", 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
